dvfs_transition_sequencer: RTL and testbench
============================================

Name: dvfs_transition_sequencer

Overview:
Sequences one DVFS level change between the DVFS policy FSM (requester) and the physical actuators, the PMU voltage regulator and the PLL. It enforces safe ordering:
- Raising: voltage first, then a settle delay, then frequency.
- Lowering: frequency first, then voltage.
Each actuator step uses a req/ack handshake with timeout. The block holds the authoritative applied freq_sel/volt_sel.

Parameters:
VOLT_SETTLE_CYCLES, 64, cycles waited after volt_ack on the up path before the PLL request (1..2^CNT_W-1)
ACK_TIMEOUT_CYCLES, 200, max cycles waiting for volt_ack or pll_ack before error (1..2^CNT_W-1)
CNT_W, 8, width of the shared wait/timeout counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  level-change request valid
req_level  in  2  target level: 00 low, 01 normal, 10 high, 11 illegal
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
done  out  1  one-cycle pulse when a request completes (ok or error)
resp_err  out  1  qualifies done: 1 = illegal level or timeout
volt_req  out  1  voltage change request to PMU, held until volt_ack
volt_level  out  2  requested voltage level, stable while volt_req=1
volt_ack  in  1  PMU one-cycle ack; sampled only while volt_req=1
pll_req  out  1  frequency change request to PLL, held until pll_ack
pll_level  out  2  requested frequency level, stable while pll_req=1
pll_ack  in  1  PLL lock ack pulse; sampled only while pll_req=1
freq_sel  out  2  currently applied frequency level
volt_sel  out  2  currently applied voltage level
busy  out  1  high in every state except IDLE
err_sticky  out  1  set on timeout; cleared only by err_clr
err_clr  in  1  clears err_sticky and exits ERROR

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; freq_sel = volt_sel = 01.
  - volt_level = pll_level = 01; volt_req, pll_req, done, resp_err, busy, err_sticky = 0.
  - Reset mid-operation aborts immediately; no completion pulse.
- All outputs are registered.
- States: IDLE, V_REQ, V_SETTLE, F_REQ, COMPLETE, ERROR. A direction flag `up` is latched at accept.
- IDLE, on accept (target latched):
  - target==11 -> COMPLETE with resp_err=1, no actuator activity.
  - target==freq_sel -> COMPLETE with resp_err=0, no actuator activity.
  - target>freq_sel -> up=1 -> V_REQ.
  - target<freq_sel -> up=0 -> F_REQ.
  - Multi-step changes (00<->10) are a single step each; no intermediate level.
- V_REQ:
  - volt_req=1 and volt_level=target from the entry cycle.
  - On volt_ack: volt_sel<=target, volt_req<=0 the next cycle; then up ? V_SETTLE : COMPLETE.
- V_SETTLE: counter loads VOLT_SETTLE_CYCLES; decrements to 0, then F_REQ. Exactly VOLT_SETTLE_CYCLES cycles with no request asserted.
- F_REQ:
  - pll_req=1 and pll_level=target.
  - On pll_ack: freq_sel<=target, pll_req<=0; then up ? COMPLETE : V_REQ.
- COMPLETE: done=1 for one cycle, then IDLE. req_ready returns 1 on the cycle after done.
- Timeout:
  - The counter reloads to ACK_TIMEOUT_CYCLES on entry to V_REQ/F_REQ.
  - If it reaches 0 without ack: drop the request, set err_sticky, pulse done with resp_err=1, go to ERROR.
  - freq_sel/volt_sel keep the last acknowledged values.
  - An ack arriving in the same cycle the counter hits 0 wins (ack has priority).
- ERROR:
  - busy=1, req_ready=0.
  - err_clr -> err_sticky<=0 -> IDLE.
  - err_clr outside ERROR clears err_sticky only.
- Ack pulses received while the matching req=0 are ignored.
- req_valid while busy is ignored (not queued); the requester holds it.
- Invariant, checked by assertion: volt_sel >= freq_sel at all times.

Decomposition:
- Package dvfs_pkg:
  - level localparams LVL_LOW=00, LVL_NORM=01, LVL_HIGH=10, LVL_ILLEGAL=11.
  - state encoding for this FSM.
  - level threshold constants shared with the policy FSM.
- Sub-module dvfs_wait_timer:
  - CNT_W-bit load/decrement counter with a zero flag.
  - Used for both settle and timeout.

Test Plan:
1. Reset, then req 01->10. Response:
   - volt_req with level 10.
   - ack after 5 cycles -> volt_sel=10.
   - exactly 64 idle cycles, then pll_req with level 10.
   - pll_ack -> freq_sel=10, done with resp_err=0.
2. From 10, req 00. Response:
   - pll_req first; after ack freq_sel=00.
   - volt_req next (no settle); after ack volt_sel=00.
   - done. volt_sel>=freq_sel holds throughout.
3. req_level=11, and separately a req equal to the current level. Each gives done on the cycle after IDLE with resp_err=1 (illegal) or 0 (equal), no volt_req/pll_req, selects unchanged.
4. Timeout paths:
   - volt_ack never arrives -> after 200 cycles volt_req=0, done+resp_err=1, err_sticky=1, state ERROR, req_ready=0.
   - err_clr -> req_ready=1.
   - Boundary: ack on the 200th cycle completes normally.
5. Abort and ignore cases:
   - rst_n low during V_SETTLE -> all outputs at reset values within the same cycle; no done.
   - req_valid pulses while busy are ignored.
   - stray pll_ack while pll_req=0 is ignored.

Source files
------------

// File: rtl/dvfs_pkg.sv
`timescale 1ns/1ps
// Shared DVFS definitions: operating-level codes, sequencer state encoding and
// the utilisation thresholds the policy FSM uses to pick a target level.
package dvfs_pkg;

    localparam logic [1:0] LVL_LOW     = 2'b00;
    localparam logic [1:0] LVL_NORM    = 2'b01;
    localparam logic [1:0] LVL_HIGH    = 2'b10;
    localparam logic [1:0] LVL_ILLEGAL = 2'b11;

    // Utilisation (0..255) thresholds for the policy FSM's raise/lower decisions
    localparam logic [7:0] UTIL_RAISE_THRESH = 8'd192;
    localparam logic [7:0] UTIL_LOWER_THRESH = 8'd64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_V_REQ,
        ST_V_SETTLE,
        ST_F_REQ,
        ST_COMPLETE,
        ST_ERROR
    } dvfs_state_t;

    function automatic logic is_legal_level(input logic [1:0] lvl);
        return lvl != LVL_ILLEGAL;
    endfunction

endpackage

// File: rtl/dvfs_wait_timer.sv
`timescale 1ns/1ps
// Load/decrement down-counter with a zero flag; shared by the voltage settle
// delay and the actuator acknowledge timeout.
module dvfs_wait_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load wins over decrement; the count saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dvfs_transition_sequencer.sv
`timescale 1ns/1ps
// Sequences one DVFS level change: voltage before frequency when raising,
// frequency before voltage when lowering, each step a req/ack with timeout.
module dvfs_transition_sequencer
    import dvfs_pkg::*;
#(
    parameter int VOLT_SETTLE_CYCLES = 64,
    parameter int ACK_TIMEOUT_CYCLES = 200,
    parameter int CNT_W              = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_level,
    output logic       req_ready,
    output logic       done,
    output logic       resp_err,
    output logic       volt_req,
    output logic [1:0] volt_level,
    input  logic       volt_ack,
    output logic       pll_req,
    output logic [1:0] pll_level,
    input  logic       pll_ack,
    output logic [1:0] freq_sel,
    output logic [1:0] volt_sel,
    output logic       busy,
    output logic       err_sticky,
    input  logic       err_clr
);

    // Loaded with N-1 so the zero flag marks the Nth cycle spent waiting
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(VOLT_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(ACK_TIMEOUT_CYCLES - 1);

    dvfs_state_t state, state_n;
    logic [1:0]  target, target_n;
    logic        up, up_n;
    logic        volt_req_n, pll_req_n, done_n, resp_err_n, err_sticky_n;
    logic [1:0]  volt_level_n, pll_level_n, freq_sel_n, volt_sel_n;
    logic        tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    dvfs_wait_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            target     <= LVL_NORM;
            up         <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            resp_err   <= 1'b0;
            volt_req   <= 1'b0;
            volt_level <= LVL_NORM;
            pll_req    <= 1'b0;
            pll_level  <= LVL_NORM;
            freq_sel   <= LVL_NORM;
            volt_sel   <= LVL_NORM;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_n;
            target     <= target_n;
            up         <= up_n;
            req_ready  <= (state_n == ST_IDLE);
            busy       <= (state_n != ST_IDLE);
            done       <= done_n;
            resp_err   <= resp_err_n;
            volt_req   <= volt_req_n;
            volt_level <= volt_level_n;
            pll_req    <= pll_req_n;
            pll_level  <= pll_level_n;
            freq_sel   <= freq_sel_n;
            volt_sel   <= volt_sel_n;
            err_sticky <= err_sticky_n;
        end
    end

    // Every output is computed here as its next value so all of them leave flops
    always_comb begin
        state_n      = state;
        target_n     = target;
        up_n         = up;
        volt_req_n   = volt_req;
        volt_level_n = volt_level;
        pll_req_n    = pll_req;
        pll_level_n  = pll_level;
        freq_sel_n   = freq_sel;
        volt_sel_n   = volt_sel;
        done_n       = 1'b0;
        resp_err_n   = 1'b0;
        err_sticky_n = err_sticky;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        tmr_val      = TIMEOUT_LOAD;

        if (err_clr) begin
            err_sticky_n = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    target_n = req_level;
                    if (!is_legal_level(req_level)) begin
                        state_n    = ST_COMPLETE;
                        done_n     = 1'b1;
                        resp_err_n = 1'b1;
                    end else if (req_level == freq_sel) begin
                        state_n = ST_COMPLETE;
                        done_n  = 1'b1;
                    end else if (req_level > freq_sel) begin
                        up_n         = 1'b1;
                        state_n      = ST_V_REQ;
                        volt_req_n   = 1'b1;
                        volt_level_n = req_level;
                        tmr_load     = 1'b1;
                    end else begin
                        up_n        = 1'b0;
                        state_n     = ST_F_REQ;
                        pll_req_n   = 1'b1;
                        pll_level_n = req_level;
                        tmr_load    = 1'b1;
                    end
                end
            end

            ST_V_REQ: begin
                // An ack in the same cycle as the timeout expiry still counts
                if (volt_ack && volt_req) begin
                    volt_sel_n = target;
                    volt_req_n = 1'b0;
                    if (up) begin
                        state_n  = ST_V_SETTLE;
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_LOAD;
                    end else begin
                        state_n = ST_COMPLETE;
                        done_n  = 1'b1;
                    end
                end else if (tmr_zero) begin
                    volt_req_n   = 1'b0;
                    err_sticky_n = 1'b1;
                    done_n       = 1'b1;
                    resp_err_n   = 1'b1;
                    state_n      = ST_ERROR;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_V_SETTLE: begin
                if (tmr_zero) begin
                    state_n     = ST_F_REQ;
                    pll_req_n   = 1'b1;
                    pll_level_n = target;
                    tmr_load    = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_F_REQ: begin
                if (pll_ack && pll_req) begin
                    freq_sel_n = target;
                    pll_req_n  = 1'b0;
                    if (up) begin
                        state_n = ST_COMPLETE;
                        done_n  = 1'b1;
                    end else begin
                        state_n      = ST_V_REQ;
                        volt_req_n   = 1'b1;
                        volt_level_n = target;
                        tmr_load     = 1'b1;
                    end
                end else if (tmr_zero) begin
                    pll_req_n    = 1'b0;
                    err_sticky_n = 1'b1;
                    done_n       = 1'b1;
                    resp_err_n   = 1'b1;
                    state_n      = ST_ERROR;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_COMPLETE: begin
                state_n = ST_IDLE;
            end

            ST_ERROR: begin
                if (err_clr) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Lowering frequency first and raising voltage first keeps this true
    a_volt_ge_freq: assert property (@(posedge clk) disable iff (!rst_n) volt_sel >= freq_sel);

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for the DVFS sequencer with behavioural PMU/PLL
// responders and a level-change reference model.
module tb_dvfs_transition_sequencer;

    localparam int SETTLE  = 64;
    localparam int TIMEOUT = 200;
    localparam int NEVER   = 1000;

    typedef struct packed {
        logic       resp_err;
        logic [1:0] freq;
        logic [1:0] volt;
        logic       sticky;
        logic [1:0] n_act;
        logic [2:0] act0;
        logic [2:0] act1;
        logic [1:0] to_kind;
        logic       lat_chk;
    } exp_t;

    logic       clk, rst_n;
    logic       req_valid, req_ready, done, resp_err;
    logic [1:0] req_level, volt_level, pll_level, freq_sel, volt_sel;
    logic       volt_req, volt_ack, pll_req, pll_ack, busy, err_sticky, err_clr;

    int checks = 0;
    int errors = 0;
    exp_t       exp_q[$];
    logic [2:0] act_q[$];
    logic [1:0] m_freq, m_volt;
    logic       m_err;
    int  volt_delay = 0, pll_delay = 0;
    bit  stray_pll = 0;
    time issue_time = 0;

    int  v_cnt = 0, p_cnt = 0;
    bit  v_prev = 0, p_prev = 0;
    int  v_hi = 0, p_hi = 0, v_len = 0, p_len = 0;
    bit  vm_prev = 0, pm_prev = 0;
    bit  settle_armed = 0;
    int  settle_gap = 0;

    dvfs_transition_sequencer #(
        .VOLT_SETTLE_CYCLES (SETTLE),
        .ACK_TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W              (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_level  (req_level),
        .req_ready  (req_ready),
        .done       (done),
        .resp_err   (resp_err),
        .volt_req   (volt_req),
        .volt_level (volt_level),
        .volt_ack   (volt_ack),
        .pll_req    (pll_req),
        .pll_level  (pll_level),
        .pll_ack    (pll_ack),
        .freq_sel   (freq_sel),
        .volt_sel   (volt_sel),
        .busy       (busy),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: outcome of one request from the current applied levels
    function automatic exp_t model(input logic [1:0] lvl, input int vd, input int pd);
        exp_t e;
        bit v_ok, p_ok;
        e = '0;
        v_ok = (vd + 1 <= TIMEOUT);
        p_ok = (pd + 1 <= TIMEOUT);
        if (lvl == 2'b11) begin
            e.resp_err = 1'b1;
            e.lat_chk  = 1'b1;
        end else if (lvl == m_freq) begin
            e.lat_chk = 1'b1;
        end else if (lvl > m_freq) begin
            e.n_act = 2'd1;
            e.act0  = {1'b0, lvl};
            if (!v_ok) begin
                e.to_kind = 2'd1;
            end else begin
                m_volt  = lvl;
                e.n_act = 2'd2;
                e.act1  = {1'b1, lvl};
                if (!p_ok) e.to_kind = 2'd2;
                else       m_freq = lvl;
            end
        end else begin
            e.n_act = 2'd1;
            e.act0  = {1'b1, lvl};
            if (!p_ok) begin
                e.to_kind = 2'd2;
            end else begin
                m_freq  = lvl;
                e.n_act = 2'd2;
                e.act1  = {1'b0, lvl};
                if (!v_ok) e.to_kind = 2'd1;
                else       m_volt = lvl;
            end
        end
        if (e.to_kind != 2'd0) begin
            e.resp_err = 1'b1;
            m_err      = 1'b1;
        end
        e.freq   = m_freq;
        e.volt   = m_volt;
        e.sticky = m_err;
        return e;
    endfunction

    task automatic applyStimulus(input logic [1:0] lvl, input int vd, input int pd,
                                 input bit busy_poke, input bit stray);
        int n;
        bit stray_sent;
        n = 0;
        stray_sent = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checkOutput("ready_wait", 0, 1);
            return;
        end
        volt_delay = vd;
        pll_delay  = pd;
        exp_q.push_back(model(lvl, vd, pd));
        issue_time = $time;
        req_valid  = 1'b1;
        req_level  = lvl;
        @(negedge clk);
        req_valid = 1'b0;
        if (busy_poke) begin
            req_valid = 1'b1;
            req_level = 2'($urandom_range(0, 3));
            @(negedge clk);
            req_valid = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
            if (stray && !stray_sent && settle_armed && settle_gap >= 10) begin
                stray_pll  = 1'b1;
                stray_sent = 1'b1;
            end
        end
        if (exp_q.size() != 0) begin
            checkOutput("done_wait", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic clearError();
        repeat (3) @(negedge clk);
        checkOutput("err_ready_low", req_ready, 0);
        checkOutput("err_sticky_set", err_sticky, 1);
        checkOutput("err_busy", busy, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("clr_ready", req_ready, 1);
        checkOutput("clr_sticky", err_sticky, 0);
        m_err = 1'b0;
    endtask

    // PMU responder: acks volt_delay cycles after each request rises
    always @(negedge clk) begin
        volt_ack = 1'b0;
        if (!rst_n) begin
            v_prev = 1'b0;
        end else begin
            if (volt_req) begin
                if (!v_prev) begin
                    v_cnt = 0;
                    act_q.push_back({1'b0, volt_level});
                end else begin
                    v_cnt++;
                end
                if (v_cnt == volt_delay) volt_ack = 1'b1;
            end
            v_prev = volt_req;
        end
    end

    // PLL responder, plus an on-demand stray ack while no request is pending
    always @(negedge clk) begin
        pll_ack = 1'b0;
        if (!rst_n) begin
            p_prev = 1'b0;
        end else begin
            if (pll_req) begin
                if (!p_prev) begin
                    p_cnt = 0;
                    act_q.push_back({1'b1, pll_level});
                end else begin
                    p_cnt++;
                end
                if (p_cnt == pll_delay) pll_ack = 1'b1;
            end else if (stray_pll) begin
                pll_ack   = 1'b1;
                stray_pll = 1'b0;
            end
            p_prev = pll_req;
        end
    end

    // Monitor: request timing, the level invariant, and scoreboard pops on done
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            act_q.delete();
            settle_armed = 1'b0;
            v_hi = 0; p_hi = 0; vm_prev = 1'b0; pm_prev = 1'b0;
        end else begin
            checkOutput("volt_ge_freq", int'(volt_sel >= freq_sel), 1);
            if (volt_req) v_hi++;
            else if (vm_prev) begin v_len = v_hi; v_hi = 0; end
            if (pll_req) p_hi++;
            else if (pm_prev) begin p_len = p_hi; p_hi = 0; end
            if (settle_armed && pll_req && !pm_prev) begin
                checkOutput("settle_gap", settle_gap, SETTLE);
                settle_armed = 1'b0;
            end else if (settle_armed) begin
                settle_gap++;
            end
            if (!volt_req && vm_prev) begin
                settle_armed = 1'b1;
                settle_gap   = 1;
            end
            if (done) begin
                settle_armed = 1'b0;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("resp_err", resp_err, e.resp_err);
                    checkOutput("freq_sel", freq_sel, e.freq);
                    checkOutput("volt_sel", volt_sel, e.volt);
                    checkOutput("err_sticky", err_sticky, e.sticky);
                    checkOutput("ready_at_done", req_ready, 0);
                    checkOutput("act_count", act_q.size(), e.n_act);
                    if (act_q.size() >= 1 && e.n_act >= 1) checkOutput("act0", act_q[0], e.act0);
                    if (act_q.size() >= 2 && e.n_act >= 2) checkOutput("act1", act_q[1], e.act1);
                    if (e.to_kind == 2'd1) checkOutput("volt_timeout_len", v_len, TIMEOUT);
                    if (e.to_kind == 2'd2) checkOutput("pll_timeout_len", p_len, TIMEOUT);
                    if (e.lat_chk) checkOutput("done_latency", int'($time - issue_time), 10);
                end
                act_q.delete();
            end
            vm_prev = volt_req;
            pm_prev = pll_req;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_level = 2'b01; err_clr = 1'b0;
        m_freq = 2'b01; m_volt = 2'b01; m_err = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {req_ready, busy, done, resp_err, err_sticky, volt_req, pll_req}, 7'b1000000);
        checkOutput("reset_levels", {volt_level, pll_level, freq_sel, volt_sel}, 8'b01010101);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(2'b10, 5, 3, 0, 0);          // raise 01->10
        applyStimulus(2'b00, 4, 2, 1, 0);          // lower 10->00 with busy poke
        applyStimulus(2'b11, 0, 0, 1, 0);          // illegal
        applyStimulus(2'b00, 0, 0, 0, 0);          // equal level
        applyStimulus(2'b01, TIMEOUT - 1, 0, 0, 0); // ack on the last allowed cycle
        applyStimulus(2'b10, NEVER, 0, 0, 0);      // volt ack timeout
        clearError();

        // Abort mid-settle with reset
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        volt_delay = 2; pll_delay = 2;
        req_valid = 1'b1; req_level = 2'b10;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(settle_armed && settle_gap >= 20) && n < 500) begin @(negedge clk); n++; end
        checkOutput("reached_settle", int'(settle_armed), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ctrl", {req_ready, busy, done, resp_err, err_sticky, volt_req, pll_req}, 7'b1000000);
        checkOutput("abort_levels", {volt_level, pll_level, freq_sel, volt_sel}, 8'b01010101);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_freq = 2'b01; m_volt = 2'b01; m_err = 1'b0;
        repeat (80) @(negedge clk);

        applyStimulus(2'b10, 3, 1, 0, 1);          // raise with stray pll_ack in settle
        applyStimulus(2'b00, 0, NEVER, 0, 0);      // pll ack timeout on the way down
        clearError();

        for (int i = 0; i < 12; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 20),
                          $urandom_range(0, 20), bit'($urandom_range(0, 1)), 0);
        end

        repeat (20) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
